// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, default drain length and the NOP instruction word.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    // Enabled cycles needed to retire the instructions already past ID (EX, MEM, WB).
    localparam int DEFAULT_DRAIN_CYCLES = 3;

    // The all-zero word (sll $0,$0,0) is what a flushed IF/ID register holds.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: hazard inputs from the pipeline (master side)
// and the stall/flush/enable controls back to it (slave is the controller).
// Plain level signals, no handshake: every value is sampled on the rising
// clock edge, and every control output applies to the cycle it is asserted in.
// The statistics ports exist only when HAZARD_STATS_EN is defined.
interface pipeline_hazard_controller_if
`ifdef HAZARD_STATS_EN
    #(parameter int NB = 5, parameter int CNT_W = 32);
`else
    #(parameter int NB = 5);
`endif
    import pipeline_hazard_controller_pkg::*;

    logic          mem_read_2_3;
    logic [NB-1:0] rt_2_3;
    logic [NB-1:0] rs_1_2;
    logic [NB-1:0] rt_1_2;
    logic          uses_rt_1_2;
    logic          halt_1_2;
    logic          branch_taken;
    logic          step_mode;
    logic          step_pulse;

    logic          pc_write;
    logic          write_1_2;
    logic          flush_1_2;
    logic          flush_2_3;
    logic          enable_pipe;
    logic          halted;
    hz_state_t     state;        // debug view of the controller FSM
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] cycle_count;
`endif

    modport master (
        output mem_read_2_3, rt_2_3, rs_1_2, rt_1_2, uses_rt_1_2, halt_1_2,
        output branch_taken, step_mode, step_pulse,
`ifdef HAZARD_STATS_EN
        input  stall_count, flush_count, cycle_count,
`endif
        input  pc_write, write_1_2, flush_1_2, flush_2_3, enable_pipe, halted, state
    );

    modport slave (
        input  mem_read_2_3, rt_2_3, rs_1_2, rt_1_2, uses_rt_1_2, halt_1_2,
        input  branch_taken, step_mode, step_pulse,
`ifdef HAZARD_STATS_EN
        output stall_count, flush_count, cycle_count,
`endif
        output pc_write, write_1_2, flush_1_2, flush_2_3, enable_pipe, halted, state
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Load-use detector: flags an IF/ID instruction that reads the register a
// load in ID/EX is about to write. $0 never creates a dependency.
module load_use_detector #(
    parameter int NB = 5
) (
    input  logic          mem_read_2_3,
    input  logic [NB-1:0] rt_2_3,
    input  logic [NB-1:0] rs_1_2,
    input  logic [NB-1:0] rt_1_2,
    input  logic          uses_rt_1_2,
    output logic          lu
);

    // rt only matters when the IF/ID instruction actually reads it as a source.
    always_comb begin
        lu = mem_read_2_3 && (rt_2_3 != '0) &&
             ((rt_2_3 == rs_1_2) || (uses_rt_1_2 && (rt_2_3 == rt_1_2)));
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for the 5-stage MIPS pipeline: load-use
// stall, taken-branch flush, debug single-step gating and HALT drain.
// Defining HAZARD_STATS_EN adds saturating stall/flush/cycle counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int len          = 32,
    parameter int NB           = $clog2(len),
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic clk,
    input  logic reset,
    pipeline_hazard_controller_if.slave hz
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    hz_state_t     state;
    logic [CW-1:0] drain_cnt;
    logic          adv;
    logic          lu;
    logic          stall_now;
    logic          flush_now;

    load_use_detector #(.NB(NB)) u_lu (
        .mem_read_2_3 (hz.mem_read_2_3),
        .rt_2_3       (hz.rt_2_3),
        .rs_1_2       (hz.rs_1_2),
        .rt_1_2       (hz.rt_1_2),
        .uses_rt_1_2  (hz.uses_rt_1_2),
        .lu           (lu)
    );

    // Control outputs decoded from current state and this cycle's hazard inputs.
    always_comb begin
        adv          = (state != HALTED) && (!hz.step_mode || hz.step_pulse);
        hz.pc_write    = 1'b0;
        hz.write_1_2   = 1'b0;
        hz.flush_1_2   = 1'b0;
        hz.flush_2_3   = 1'b0;
        hz.enable_pipe = 1'b0;
        hz.halted      = 1'b0;
        stall_now    = 1'b0;
        flush_now    = 1'b0;
        if (reset) begin
            // Hold the front end cleared until reset releases.
            hz.flush_1_2 = 1'b1;
            hz.flush_2_3 = 1'b1;
        end else if (state == HALTED) begin
            hz.halted = 1'b1;
        end else if (adv) begin
            hz.enable_pipe = 1'b1;
            if (state == RUN) begin
                if (hz.branch_taken) begin
                    // Taken branch wins: anything in IF/ID (even HALT) is wrong-path.
                    hz.pc_write  = 1'b1;
                    hz.write_1_2 = 1'b1;
                    hz.flush_1_2 = 1'b1;
                    hz.flush_2_3 = 1'b1;
                    flush_now    = 1'b1;
                end else if (hz.halt_1_2 || lu) begin
                    // HALT freezes fetch like a stall; it masks any load-use hazard.
                    hz.flush_2_3 = 1'b1;
                    stall_now    = !hz.halt_1_2;
                end else begin
                    hz.pc_write  = 1'b1;
                    hz.write_1_2 = 1'b1;
                end
            end else begin
                // DRAIN: retire older instructions, feed bubbles behind them.
                hz.flush_2_3 = 1'b1;
            end
        end
    end

    // FSM and drain counter; both hold on any cycle the pipeline does not advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else if (adv) begin
            case (state)
                RUN: begin
                    if (!hz.branch_taken && hz.halt_1_2) begin
                        state     <= DRAIN;
                        drain_cnt <= CW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    assign hz.state = state;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    // Saturating event counters for stalls, branch flushes and enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if (stall_now && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_now && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            if (adv && (cycle_cnt != '1))       cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;
    assign hz.cycle_count = cycle_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller. Define HAZARD_STATS_EN
// to also exercise the statistics counters.
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    localparam int NB = 5;
    localparam int W  = 8;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;
    logic [W-1:0] exp_q[$];

    pipeline_hazard_controller_if #(.NB(NB)) hz_if ();

    pipeline_hazard_controller dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected-vector helpers ----------------
    // Packed as {state, pc_write, write_1_2, flush_1_2, flush_2_3, enable_pipe, halted}.
    function automatic logic [W-1:0] ev(input hz_state_t st, input bit pw, input bit w12,
                                        input bit f12, input bit f23, input bit en, input bit h);
        return {st, pw, w12, f12, f23, en, h};
    endfunction

    function automatic logic [W-1:0] e_rst(input hz_state_t st);
        return ev(st, 0, 0, 1, 1, 0, 0);
    endfunction

    function automatic logic [W-1:0] e_idle(input hz_state_t st);
        return ev(st, 0, 0, 0, 0, 0, 0);
    endfunction

    logic [W-1:0] e_run, e_stall, e_flush, e_drain, e_halt;
    initial begin
        e_run   = ev(RUN,    1, 1, 0, 0, 1, 0);
        e_stall = ev(RUN,    0, 0, 0, 1, 1, 0);
        e_flush = ev(RUN,    1, 1, 1, 1, 1, 0);
        e_drain = ev(DRAIN,  0, 0, 0, 1, 1, 0);
        e_halt  = ev(HALTED, 0, 0, 0, 0, 0, 1);
    end

    // ---------------- checker / scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] observed();
        return {hz_if.state, hz_if.pc_write, hz_if.write_1_2, hz_if.flush_1_2,
                hz_if.flush_2_3, hz_if.enable_pipe, hz_if.halted};
    endfunction

    // One clock cycle: inputs were set at the preceding negedge; push the
    // expectation, let the outputs settle, compare, then move to the next negedge.
    task automatic cyc(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] e;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'(observed()), 32'(e));
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        hz_if.mem_read_2_3 = 1'b0;
        hz_if.rt_2_3       = '0;
        hz_if.rs_1_2       = '0;
        hz_if.rt_1_2       = '0;
        hz_if.uses_rt_1_2  = 1'b0;
        hz_if.halt_1_2     = 1'b0;
        hz_if.branch_taken = 1'b0;
        hz_if.step_mode    = 1'b0;
        hz_if.step_pulse   = 1'b0;
    endtask

    task automatic drive_load(input logic [NB-1:0] ld_rt, input logic [NB-1:0] rs,
                              input logic [NB-1:0] rt, input logic use_rt);
        hz_if.mem_read_2_3 = 1'b1;
        hz_if.rt_2_3       = ld_rt;
        hz_if.rs_1_2       = rs;
        hz_if.rt_1_2       = rt;
        hz_if.uses_rt_1_2  = use_rt;
    endtask

    task automatic clear_load();
        hz_if.mem_read_2_3 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NB-1:0] r, o;
        chk_cnt  = 0;
        pass_cnt = 0;
        drive_idle();
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        cyc("reset_0", e_rst(RUN));
        cyc("reset_1", e_rst(RUN));
        reset = 1'b0;
        cyc("run_idle", e_run);

        // Load-use on rs: one stall cycle, then the bubble clears the hazard.
        r = NB'($urandom_range(1, 31));
        o = (r == 5'd31) ? 5'd1 : r + 5'd1;
        drive_load(r, r, o, 1'b0);
        cyc("lu_rs_stall", e_stall);
        clear_load();
        cyc("lu_rs_after", e_run);

        // Load-use on rt when rt is a source.
        drive_load(r, o, r, 1'b1);
        cyc("lu_rt_stall", e_stall);
        clear_load();
        cyc("lu_rt_after", e_run);

        // rt match but rt not read: no stall.
        drive_load(r, o, r, 1'b0);
        cyc("lu_rt_unused", e_run);

        // Load into $0: never a hazard.
        drive_load(5'd0, 5'd0, 5'd0, 1'b1);
        cyc("lu_r0", e_run);

        // Non-load with matching registers: no stall.
        drive_load(r, r, r, 1'b1);
        clear_load();
        cyc("no_load", e_run);

        // Branch overrides both load-use and HALT; stays in RUN.
        drive_load(r, r, o, 1'b0);
        hz_if.halt_1_2     = 1'b1;
        hz_if.branch_taken = 1'b1;
        cyc("branch_all", e_flush);
        drive_idle();
        cyc("branch_after", e_run);

        // HALT masks load-use; drain 3 cycles (branch ignored), then freeze.
        hz_if.halt_1_2 = 1'b1;
        drive_load(r, r, o, 1'b0);
        cyc("halt_detect", e_stall);
        cyc("drain_0", e_drain);
        hz_if.branch_taken = 1'b1;
        cyc("drain_1_br", e_drain);
        hz_if.branch_taken = 1'b0;
        cyc("drain_2", e_drain);
        cyc("halted_0", e_halt);
        hz_if.step_mode  = 1'b1;
        hz_if.step_pulse = 1'b1;
        cyc("halted_1", e_halt);
        drive_idle();
        cyc("halted_2", e_halt);

        // One reset edge leaves HALTED.
        reset = 1'b1;
        cyc("reset_halt", e_rst(HALTED));
        reset = 1'b0;
        cyc("unhalt_run", e_run);

        // Reset in the middle of a drain.
        hz_if.halt_1_2 = 1'b1;
        cyc("halt2_detect", e_stall);
        cyc("halt2_drain", e_drain);
        reset = 1'b1;
        cyc("reset_drain", e_rst(DRAIN));
        reset = 1'b0;
        hz_if.halt_1_2 = 1'b0;
        cyc("undrain_run", e_run);

        // Step mode, pulse every 4th cycle, with a pending load-use stall.
        hz_if.step_mode = 1'b1;
        drive_load(r, r, o, 1'b0);
        for (int i = 0; i < 12; i++) begin
            hz_if.step_pulse = (i % 4 == 3);
            if (i == 4) clear_load();   // the bubble reached ID/EX after the first step
            if (i % 4 != 3)  cyc($sformatf("step_gap_%0d", i), e_idle(RUN));
            else if (i == 3) cyc("step_lu", e_stall);
            else             cyc($sformatf("step_run_%0d", i), e_run);
        end

        // Step mode drain: HALT takes one step, drain consumes three more.
        hz_if.halt_1_2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hz_if.step_pulse = (i % 4 == 3);
            if (i < 3)       cyc($sformatf("sh_gap_%0d", i), e_idle(RUN));
            else if (i == 3) cyc("sh_detect", e_stall);
            else if (i % 4 != 3) cyc($sformatf("sh_gap_%0d", i), e_idle(DRAIN));
            else             cyc($sformatf("sh_drain_%0d", i), e_drain);
        end
        cyc("sh_halted", e_halt);

        // step_mode drop takes effect in the same cycle (after a reset).
        drive_idle();
        reset = 1'b1;
        cyc("reset_step", e_rst(HALTED));
        reset = 1'b0;
        hz_if.step_mode = 1'b1;
        cyc("step_hold", e_idle(RUN));
        hz_if.step_mode = 1'b0;
        cyc("step_off", e_run);

`ifdef HAZARD_STATS_EN
        // 10 free-running cycles: 2 load-use stalls and 1 branch flush.
        drive_idle();
        reset = 1'b1;
        cyc("stats_reset", e_rst(RUN));
        reset = 1'b0;
        check("stats_zero", hz_if.cycle_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive_idle();
            if (i == 1 || i == 6) drive_load(r, r, o, 1'b0);
            if (i == 4) hz_if.branch_taken = 1'b1;
            if (i == 1 || i == 6)  cyc($sformatf("stats_lu_%0d", i), e_stall);
            else if (i == 4)       cyc("stats_br", e_flush);
            else                   cyc($sformatf("stats_run_%0d", i), e_run);
        end
        #1;
        check("stall_count", hz_if.stall_count, 32'd2);
        check("flush_count", hz_if.flush_count, 32'd1);
        check("cycle_count", hz_if.cycle_count, 32'd10);
`endif

        // ---------------- final report ----------------
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
